arp_rx_deframer: RTL

- Upstream neighbour of the ARP frame checker. Consumes an 8-bit AXI-Stream Ethernet RX byte stream with FCS already stripped.
- Assembles the first 42 bytes of each frame into a proto_frame_t.
- Presents each complete frame through a one-entry valid/ready output register.
- Drops runt, errored and oversize frames and counts good and dropped frames.
- Does no field checking; the downstream validate_proto_frame stage owns that.

---
 rtl/arp_pkg.sv | 42 ++++
 rtl/arp_rx_deframer.sv | 117 +++++++++++
 2 files changed

// File: rtl/arp_pkg.sv
// Shared ARP/Ethernet frame types for the RX deframer and the downstream frame checker.
package arp_pkg;

  localparam int unsigned lp_PROTO_FRM_SZ = 42;
  localparam logic [47:0] lp_BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // Field order matches wire order: dst_mac[47:40] is the first byte received.
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } proto_frame_t;

  // Broadcast ARP request from sha/spa asking for tpa.
  function automatic proto_frame_t proto_ref(input logic [47:0] sha, input logic [31:0] spa,
                                             input logic [31:0] tpa);
    proto_frame_t f;
    f.dst_mac  = lp_BROADCAST_MAC;
    f.src_mac  = sha;
    f.eth_type = 16'h0806;
    f.htype    = 16'h0001;
    f.ptype    = 16'h0800;
    f.hlen     = 8'd6;
    f.plen     = 8'd4;
    f.oper     = 16'h0001;
    f.sha      = sha;
    f.spa      = spa;
    f.tha      = 48'h0;
    f.tpa      = tpa;
    return f;
  endfunction

endpackage

// File: rtl/arp_rx_deframer.sv
// Assembles the first 42 bytes of each RX frame into a proto_frame_t behind a one-entry
// output register; drops runt, errored and oversize frames and counts good/dropped frames.
module arp_rx_deframer
  import arp_pkg::*;
#(
  parameter int unsigned p_MAX_FRM_BYTES = 1514,
  parameter int unsigned p_CNT_W         = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         s_tdata_i,
  input  logic               s_tvalid_i,
  input  logic               s_tlast_i,
  input  logic               s_tuser_i,
  output logic               s_tready_o,
  output proto_frame_t       frame_o,
  output logic               frame_valid_o,
  input  logic               frame_ready_i,
  output logic [p_CNT_W-1:0] ok_cnt_o,
  output logic [p_CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned CntW = $clog2(p_MAX_FRM_BYTES + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(p_MAX_FRM_BYTES);
  localparam logic [CntW-1:0] FrmCnt = CntW'(lp_PROTO_FRM_SZ);

  typedef enum logic [1:0] {StRecv, StHold, StDrop} state_e;

  state_e                   state_q;
  logic [CntW-1:0]          cnt_q;
  logic                     err_q;
  logic [8*lp_PROTO_FRM_SZ-1:0] shift_q;
  proto_frame_t             frame_q;
  logic                     valid_q;
  logic                     tready_q;
  logic [p_CNT_W-1:0]       ok_q;
  logic [p_CNT_W-1:0]       drop_q;

  logic                     beat;
  logic [CntW-1:0]          cnt_inc;
  logic                     err_now;
  logic [8*lp_PROTO_FRM_SZ-1:0] shift_nxt;

  assign beat      = s_tvalid_i && tready_q;
  assign cnt_inc   = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CntW'(1);
  assign err_now   = err_q | s_tuser_i;
  assign shift_nxt = (cnt_q < FrmCnt) ? {shift_q[8*lp_PROTO_FRM_SZ-9:0], s_tdata_i} : shift_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StRecv;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      shift_q  <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
      tready_q <= 1'b1;
      ok_q     <= '0;
      drop_q   <= '0;
    end else begin
      unique case (state_q)
        StRecv: begin
          if (beat) begin
            shift_q <= shift_nxt;
            if (s_tlast_i) begin
              cnt_q <= '0;
              err_q <= 1'b0;
              if (cnt_inc < FrmCnt || err_now) begin
                drop_q <= drop_q + p_CNT_W'(1);
              end else begin
                frame_q  <= proto_frame_t'(shift_nxt);
                valid_q  <= 1'b1;
                ok_q     <= ok_q + p_CNT_W'(1);
                tready_q <= 1'b0;
                state_q  <= StHold;
              end
            end else begin
              cnt_q <= cnt_inc;
              err_q <= err_now;
              // A non-last beat at the size limit means the frame is too long.
              if (cnt_inc == MaxCnt) begin
                state_q <= StDrop;
              end
            end
          end
        end
        StDrop: begin
          if (beat && s_tlast_i) begin
            drop_q  <= drop_q + p_CNT_W'(1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= StRecv;
          end
        end
        StHold: begin
          if (frame_ready_i) begin
            valid_q  <= 1'b0;
            tready_q <= 1'b1;
            state_q  <= StRecv;
          end
        end
        default: begin
          state_q  <= StRecv;
          tready_q <= 1'b1;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s_tready_o    = tready_q;
  assign frame_o       = frame_q;
  assign frame_valid_o = valid_q;
  assign ok_cnt_o      = ok_q;
  assign drop_cnt_o    = drop_q;

endmodule
